// File: rtl/axil_req_arbiter_if.sv
// Bundle of the local requester ports and the AXI4-Lite master port of axil_req_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface axil_req_arbiter_if #(
   parameter int unsigned NREQ       = 2,
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [NREQ-1:0]            req_valid;
   logic [NREQ-1:0]            req_ready;
   logic [NREQ-1:0]            req_write;
   logic [NREQ*ADDR_WIDTH-1:0] req_addr;
   logic [NREQ*DATA_WIDTH-1:0] req_wdata;
   logic [NREQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]      rsp_rdata;
   logic                       rsp_err;
   logic                       busy;

   logic [ADDR_WIDTH-1:0]      M_AXI_awaddr;
   logic [2:0]                 M_AXI_awprot;
   logic                       M_AXI_awvalid;
   logic                       M_AXI_awready;
   logic [DATA_WIDTH-1:0]      M_AXI_wdata;
   logic [DATA_WIDTH/8-1:0]    M_AXI_wstrb;
   logic                       M_AXI_wvalid;
   logic                       M_AXI_wready;
   logic [1:0]                 M_AXI_bresp;
   logic                       M_AXI_bvalid;
   logic                       M_AXI_bready;
   logic [ADDR_WIDTH-1:0]      M_AXI_araddr;
   logic [2:0]                 M_AXI_arprot;
   logic                       M_AXI_arvalid;
   logic                       M_AXI_arready;
   logic [DATA_WIDTH-1:0]      M_AXI_rdata;
   logic [1:0]                 M_AXI_rresp;
   logic                       M_AXI_rvalid;
   logic                       M_AXI_rready;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
      output M_AXI_awaddr, M_AXI_awprot, M_AXI_awvalid,
      input  M_AXI_awready,
      output M_AXI_wdata, M_AXI_wstrb, M_AXI_wvalid,
      input  M_AXI_wready,
      input  M_AXI_bresp, M_AXI_bvalid,
      output M_AXI_bready,
      output M_AXI_araddr, M_AXI_arprot, M_AXI_arvalid,
      input  M_AXI_arready,
      input  M_AXI_rdata, M_AXI_rresp, M_AXI_rvalid,
      output M_AXI_rready
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
      input  M_AXI_awaddr, M_AXI_awprot, M_AXI_awvalid,
      output M_AXI_awready,
      input  M_AXI_wdata, M_AXI_wstrb, M_AXI_wvalid,
      output M_AXI_wready,
      output M_AXI_bresp, M_AXI_bvalid,
      input  M_AXI_bready,
      input  M_AXI_araddr, M_AXI_arprot, M_AXI_arvalid,
      output M_AXI_arready,
      output M_AXI_rdata, M_AXI_rresp, M_AXI_rvalid,
      input  M_AXI_rready
   );
endinterface

// File: rtl/axil_req_arbiter.sv
// Round-robin sharing of one AXI4-Lite master port among NREQ local requesters,
// one single-word transaction in flight at a time, one-cycle response pulse to the owner.
module axil_req_arbiter #(
   parameter int unsigned NREQ       = 2,
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic               axi_aclk,
   input  logic               axi_areset,
   axil_req_arbiter_if.master bus
);
   localparam int unsigned PTR_W = $clog2(NREQ);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WADDR = 3'd1;
   localparam logic [2:0] S_WRESP = 3'd2;
   localparam logic [2:0] S_RADDR = 3'd3;
   localparam logic [2:0] S_RDATA = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]            r_state,     w_state_nxt;
   logic [PTR_W-1:0]      r_rr_ptr,    w_rr_nxt;
   logic [NREQ-1:0]       r_owner,     w_owner_nxt;
   logic [ADDR_WIDTH-1:0] r_addr,      w_addr_nxt;
   logic [DATA_WIDTH-1:0] r_wdata,     w_wdata_nxt;
   logic                  r_awvalid,   w_awvalid_nxt;
   logic                  r_wvalid,    w_wvalid_nxt;
   logic                  r_bready,    w_bready_nxt;
   logic                  r_arvalid,   w_arvalid_nxt;
   logic                  r_rready,    w_rready_nxt;
   logic [NREQ-1:0]       r_rsp_valid, w_rsp_valid_nxt;
   logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
   logic                  r_rsp_err,   w_rsp_err_nxt;
   logic                  r_busy,      w_busy_nxt;

   logic [NREQ-1:0]       w_grant;
   logic                  w_found;
   logic [PTR_W-1:0]      w_cand;
   logic [PTR_W-1:0]      w_sel;

   logic [ADDR_WIDTH-3:0] w_req_addr_hi [NREQ];
   logic [DATA_WIDTH-1:0] w_req_wdata   [NREQ];
   logic [2*NREQ-1:0]     w_unused_lsb;
   logic                  w_unused_resp;

   // Unpack per-requester command fields; address bits [1:0] are word-offset and ignored
   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign w_req_addr_hi[i]        = bus.req_addr[i*ADDR_WIDTH+2 +: ADDR_WIDTH-2];
      assign w_unused_lsb[2*i +: 2]  = bus.req_addr[i*ADDR_WIDTH +: 2];
      assign w_req_wdata[i]          = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
   end
   assign w_unused_resp = bus.M_AXI_bresp[0] ^ bus.M_AXI_rresp[0];

   // Next-state, grant selection and next values of all registered outputs
   always_comb begin
      w_state_nxt     = r_state;
      w_rr_nxt        = r_rr_ptr;
      w_owner_nxt     = r_owner;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_awvalid_nxt   = r_awvalid;
      w_wvalid_nxt    = r_wvalid;
      w_bready_nxt    = r_bready;
      w_arvalid_nxt   = r_arvalid;
      w_rready_nxt    = r_rready;
      w_rsp_valid_nxt = '0;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_err_nxt   = r_rsp_err;
      w_busy_nxt      = r_busy;
      w_grant         = '0;
      w_found         = 1'b0;
      w_cand          = '0;
      w_sel           = '0;

      // First valid requester at or after the round-robin pointer
      if (r_state == S_IDLE && !axi_areset) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            w_cand = PTR_W'((32'(r_rr_ptr) + k) % NREQ);
            if (!w_found && bus.req_valid[w_cand]) begin
               w_found = 1'b1;
               w_sel   = w_cand;
            end
         end
         if (w_found) begin
            w_grant[w_sel] = 1'b1;
         end
      end

      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_owner_nxt = w_grant;
               w_rr_nxt    = (w_sel == PTR_W'(NREQ - 1)) ? '0 : PTR_W'(32'(w_sel) + 32'd1);
               w_addr_nxt  = {w_req_addr_hi[w_sel], 2'b00};
               w_wdata_nxt = w_req_wdata[w_sel];
               w_busy_nxt  = 1'b1;
               if (bus.req_write[w_sel]) begin
                  w_state_nxt   = S_WADDR;
                  w_awvalid_nxt = 1'b1;
                  w_wvalid_nxt  = 1'b1;
               end else begin
                  w_state_nxt   = S_RADDR;
                  w_arvalid_nxt = 1'b1;
               end
            end
         end
         S_WADDR: begin
            if (bus.M_AXI_awready) w_awvalid_nxt = 1'b0;
            if (bus.M_AXI_wready)  w_wvalid_nxt  = 1'b0;
            if ((!r_awvalid || bus.M_AXI_awready) && (!r_wvalid || bus.M_AXI_wready)) begin
               w_state_nxt   = S_WRESP;
               w_awvalid_nxt = 1'b0;
               w_wvalid_nxt  = 1'b0;
               w_bready_nxt  = 1'b1;
            end
         end
         S_WRESP: begin
            if (bus.M_AXI_bvalid) begin
               w_state_nxt     = S_DONE;
               w_bready_nxt    = 1'b0;
               w_rsp_valid_nxt = r_owner;
               w_rsp_rdata_nxt = '0;
               w_rsp_err_nxt   = bus.M_AXI_bresp[1];
            end
         end
         S_RADDR: begin
            if (bus.M_AXI_arready) begin
               w_state_nxt   = S_RDATA;
               w_arvalid_nxt = 1'b0;
               w_rready_nxt  = 1'b1;
            end
         end
         S_RDATA: begin
            if (bus.M_AXI_rvalid) begin
               w_state_nxt     = S_DONE;
               w_rready_nxt    = 1'b0;
               w_rsp_valid_nxt = r_owner;
               w_rsp_rdata_nxt = bus.M_AXI_rdata;
               w_rsp_err_nxt   = bus.M_AXI_rresp[1];
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_awvalid_nxt = 1'b0;
            w_wvalid_nxt  = 1'b0;
            w_bready_nxt  = 1'b0;
            w_arvalid_nxt = 1'b0;
            w_rready_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rr_ptr    <= w_rr_nxt;
         r_owner     <= w_owner_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_awvalid   <= w_awvalid_nxt;
         r_wvalid    <= w_wvalid_nxt;
         r_bready    <= w_bready_nxt;
         r_arvalid   <= w_arvalid_nxt;
         r_rready    <= w_rready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   assign bus.req_ready     = w_grant;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_rdata     = r_rsp_rdata;
   assign bus.rsp_err       = r_rsp_err;
   assign bus.busy          = r_busy;

   assign bus.M_AXI_awaddr  = r_addr;
   assign bus.M_AXI_awprot  = 3'b000;
   assign bus.M_AXI_awvalid = r_awvalid;
   assign bus.M_AXI_wdata   = r_wdata;
   assign bus.M_AXI_wstrb   = '1;
   assign bus.M_AXI_wvalid  = r_wvalid;
   assign bus.M_AXI_bready  = r_bready;
   assign bus.M_AXI_araddr  = r_addr;
   assign bus.M_AXI_arprot  = 3'b000;
   assign bus.M_AXI_arvalid = r_arvalid;
   assign bus.M_AXI_rready  = r_rready;
endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed bench for axil_req_arbiter with a small configurable AXI4-Lite slave model.
module tb_axil_req_arbiter;
   localparam int unsigned NREQ = 2;
   localparam int unsigned AW   = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axil_req_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

   axil_req_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .axi_aclk   (clk),
      .axi_areset (rst),
      .bus        (bus)
   );

   // Slave model knobs
   int          cfg_aw_wait = 0;
   int          cfg_w_wait  = 0;
   int          cfg_ar_wait = 0;
   bit          cfg_b_stall = 1'b0;
   logic [1:0]  cfg_bresp   = 2'b00;
   logic [1:0]  cfg_rresp   = 2'b00;
   logic [31:0] cfg_rdata   = 32'h0;

   logic [3:0]  aw_cnt, w_cnt, ar_cnt;
   logic        got_aw, got_w;
   logic        aw_hs, w_hs, ar_hs;

   assign bus.M_AXI_awready = bus.M_AXI_awvalid && (int'(aw_cnt) >= cfg_aw_wait);
   assign bus.M_AXI_wready  = bus.M_AXI_wvalid  && (int'(w_cnt)  >= cfg_w_wait);
   assign bus.M_AXI_arready = bus.M_AXI_arvalid && (int'(ar_cnt) >= cfg_ar_wait);
   assign aw_hs = bus.M_AXI_awvalid && bus.M_AXI_awready;
   assign w_hs  = bus.M_AXI_wvalid  && bus.M_AXI_wready;
   assign ar_hs = bus.M_AXI_arvalid && bus.M_AXI_arready;

   always @(posedge clk) begin
      if (rst) begin
         aw_cnt <= '0; w_cnt <= '0; ar_cnt <= '0;
         got_aw <= 1'b0; got_w <= 1'b0;
         bus.M_AXI_bvalid <= 1'b0; bus.M_AXI_bresp <= 2'b00;
         bus.M_AXI_rvalid <= 1'b0; bus.M_AXI_rresp <= 2'b00; bus.M_AXI_rdata <= '0;
      end else begin
         aw_cnt <= (bus.M_AXI_awvalid && !aw_hs) ? aw_cnt + 4'd1 : 4'd0;
         w_cnt  <= (bus.M_AXI_wvalid  && !w_hs)  ? w_cnt  + 4'd1 : 4'd0;
         ar_cnt <= (bus.M_AXI_arvalid && !ar_hs) ? ar_cnt + 4'd1 : 4'd0;
         if (aw_hs) got_aw <= 1'b1;
         if (w_hs)  got_w  <= 1'b1;
         if ((got_aw || aw_hs) && (got_w || w_hs) && !cfg_b_stall && !bus.M_AXI_bvalid) begin
            bus.M_AXI_bvalid <= 1'b1;
            bus.M_AXI_bresp  <= cfg_bresp;
            got_aw <= 1'b0;
            got_w  <= 1'b0;
         end
         if (bus.M_AXI_bvalid && bus.M_AXI_bready) bus.M_AXI_bvalid <= 1'b0;
         if (ar_hs) begin
            bus.M_AXI_rvalid <= 1'b1;
            bus.M_AXI_rdata  <= cfg_rdata;
            bus.M_AXI_rresp  <= cfg_rresp;
         end
         if (bus.M_AXI_rvalid && bus.M_AXI_rready) bus.M_AXI_rvalid <= 1'b0;
      end
   end

   int        n_vec = 0;
   int        n_err = 0;
   int        cyc = 0;
   int        rsp_cnt = 0;
   int        last_grant = 0;
   int        grant_q[$];
   int        grant_cyc[$];
   logic [1:0] cont = 2'b00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // Advance one cycle: log handshakes, retire accepted commands, check response ownership
   task automatic tick();
      logic [1:0] hs;
      hs = bus.req_valid & bus.req_ready;
      @(negedge clk);
      cyc++;
      for (int r = 0; r < 2; r++) begin
         if (hs[r]) begin
            grant_q.push_back(r);
            grant_cyc.push_back(cyc);
            last_grant = r;
            if (!cont[r]) bus.req_valid[r] = 1'b0;
         end
      end
      #1;
      if (bus.rsp_valid != '0) begin
         rsp_cnt++;
         check("rsp_owner", 32'(bus.rsp_valid), 32'(1) << last_grant);
      end
   endtask

   task automatic issue(input int r, input bit wr, input logic [5:0] a, input logic [31:0] d);
      bus.req_valid[r]          = 1'b1;
      bus.req_write[r]          = wr;
      bus.req_addr[r*6 +: 6]    = a;
      bus.req_wdata[r*32 +: 32] = d;
      #1;
   endtask

   task automatic wait_rsps(input string tag, input int n, input int budget);
      int start;
      start = rsp_cnt;
      for (int i = 0; i < budget && (rsp_cnt - start) < n; i++) tick();
      check(tag, 32'(rsp_cnt - start), 32'(n));
   endtask

   initial begin
      int base;
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      @(negedge clk);
      bus.req_valid[0] = 1'b1;
      tick();
      tick();
      // Reset state, including no grant while reset is held
      check("rst_ready",   32'(bus.req_ready), 32'h0);
      check("rst_busy",    32'(bus.busy), 32'h0);
      check("rst_awvalid", 32'(bus.M_AXI_awvalid), 32'h0);
      check("rst_arvalid", 32'(bus.M_AXI_arvalid), 32'h0);
      check("rst_rspv",    32'(bus.rsp_valid), 32'h0);
      check("rst_rdata",   bus.rsp_rdata, 32'h0);
      check("rst_err",     32'(bus.rsp_err), 32'h0);
      bus.req_valid = '0;
      rst = 1'b0;
      #1;

      // Zero-wait write from requester 0
      issue(0, 1'b1, 6'h08, 32'h0000_0003);
      check("t1_grant", 32'(bus.req_ready), 32'h1);
      tick();
      check("t1_awvalid", 32'(bus.M_AXI_awvalid), 32'h1);
      check("t1_wvalid",  32'(bus.M_AXI_wvalid), 32'h1);
      check("t1_awaddr",  32'(bus.M_AXI_awaddr), 32'h08);
      check("t1_wdata",   bus.M_AXI_wdata, 32'h3);
      check("t1_wstrb",   32'(bus.M_AXI_wstrb), 32'hF);
      check("t1_awprot",  32'(bus.M_AXI_awprot), 32'h0);
      check("t1_busy",    32'(bus.busy), 32'h1);
      tick();
      check("t1_bready",  32'(bus.M_AXI_bready), 32'h1);
      check("t1_awdrop",  32'(bus.M_AXI_awvalid), 32'h0);
      tick();
      check("t1_rspv",    32'(bus.rsp_valid), 32'h1);
      check("t1_err",     32'(bus.rsp_err), 32'h0);
      check("t1_rdata",   bus.rsp_rdata, 32'h0);
      tick();
      check("t1_idle",    32'(bus.busy), 32'h0);

      // Read from requester 1 with a slow arready
      cfg_ar_wait = 3;
      cfg_rdata   = 32'hDEAD_BEEF;
      issue(1, 1'b0, 6'h00, 32'h0);
      check("t2_grant", 32'(bus.req_ready), 32'h2);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t2_arvalid_hold", 32'(bus.M_AXI_arvalid), 32'h1);
         check("t2_rready_low",   32'(bus.M_AXI_rready), 32'h0);
      end
      check("t2_araddr", 32'(bus.M_AXI_araddr), 32'h00);
      wait_rsps("t2_rsp_count", 1, 10);
      check("t2_rspv",  32'(bus.rsp_valid), 32'h2);
      check("t2_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
      tick();
      check("t2_busy_after", 32'(bus.busy), 32'h0);
      cfg_ar_wait = 0;

      // Both requesters continuously valid from reset: alternate service
      rst = 1'b1;
      tick();
      rst = 1'b0;
      grant_q.delete();
      grant_cyc.delete();
      cont = 2'b11;
      issue(0, 1'b1, 6'h04, 32'h0000_0011);
      issue(1, 1'b0, 6'h0C, 32'h0);
      wait_rsps("t3_rsp_count", 4, 40);
      bus.req_valid = '0;
      cont = 2'b00;
      check("t3_ngrants", 32'(grant_q.size()), 32'd4);
      if (grant_q.size() >= 4) begin
         check("t3_order0", 32'(grant_q[0]), 32'd0);
         check("t3_order1", 32'(grant_q[1]), 32'd1);
         check("t3_order2", 32'(grant_q[2]), 32'd0);
         check("t3_order3", 32'(grant_q[3]), 32'd1);
         check("t3_period", 32'(grant_cyc[1] - grant_cyc[0]), 32'd4);
      end
      tick();
      tick();
      check("t3_no_txn_busy", 32'(bus.busy), 32'h0);
      check("t3_no_txn_grant", 32'(grant_q.size()), 32'd4);

      // Write data accepted two cycles before the address
      cfg_aw_wait = 2;
      issue(0, 1'b1, 6'h10, 32'hA5A5_A5A5);
      check("t4_grant", 32'(bus.req_ready), 32'h1);
      tick();
      check("t4_both_valid", 32'({bus.M_AXI_awvalid, bus.M_AXI_wvalid}), 32'h3);
      tick();
      check("t4_wdrop",    32'(bus.M_AXI_wvalid), 32'h0);
      check("t4_awhold",   32'(bus.M_AXI_awvalid), 32'h1);
      check("t4_awaddr",   32'(bus.M_AXI_awaddr), 32'h10);
      check("t4_bready0",  32'(bus.M_AXI_bready), 32'h0);
      tick();
      check("t4_awhold2",  32'(bus.M_AXI_awvalid), 32'h1);
      check("t4_bready1",  32'(bus.M_AXI_bready), 32'h0);
      tick();
      check("t4_awdrop",   32'(bus.M_AXI_awvalid), 32'h0);
      check("t4_bready2",  32'(bus.M_AXI_bready), 32'h1);
      wait_rsps("t4_rsp_count", 1, 10);
      check("t4_rspv", 32'(bus.rsp_valid), 32'h1);
      base = rsp_cnt;
      tick();
      tick();
      tick();
      check("t4_single_rsp", 32'(rsp_cnt - base), 32'd0);
      cfg_aw_wait = 0;

      // Error response, then a clean read
      cfg_bresp = 2'b10;
      issue(1, 1'b1, 6'h14, 32'h1);
      check("t5_grant", 32'(bus.req_ready), 32'h2);
      wait_rsps("t5_rsp_count", 1, 10);
      check("t5_rspv",  32'(bus.rsp_valid), 32'h2);
      check("t5_err",   32'(bus.rsp_err), 32'h1);
      cfg_bresp = 2'b00;
      cfg_rdata = 32'h1234_5678;
      issue(0, 1'b0, 6'h18, 32'h0);
      wait_rsps("t5b_rsp_count", 1, 10);
      check("t5b_err",   32'(bus.rsp_err), 32'h0);
      check("t5b_rdata", bus.rsp_rdata, 32'h1234_5678);
      tick();

      // Reset while waiting on a stalled write response
      cfg_b_stall = 1'b1;
      issue(0, 1'b1, 6'h1C, 32'h7);
      check("t6_grant", 32'(bus.req_ready), 32'h1);
      tick();
      tick();
      check("t6_bready_wait", 32'(bus.M_AXI_bready), 32'h1);
      tick();
      check("t6_stall_busy", 32'(bus.busy), 32'h1);
      base = rsp_cnt;
      rst = 1'b1;
      issue(0, 1'b1, 6'h20, 32'h9);
      issue(1, 1'b0, 6'h24, 32'h0);
      check("t6_ready_in_rst", 32'(bus.req_ready), 32'h0);
      tick();
      check("t6_bready_rst", 32'(bus.M_AXI_bready), 32'h0);
      check("t6_busy_rst",   32'(bus.busy), 32'h0);
      check("t6_no_rsp",     32'(rsp_cnt - base), 32'd0);
      rst = 1'b0;
      cfg_b_stall = 1'b0;
      #1;
      check("t6_rr_reset", 32'(bus.req_ready), 32'h1);
      wait_rsps("t6_rsp_count", 2, 30);
      if (grant_q.size() >= 2) begin
         check("t6_first",  32'(grant_q[grant_q.size()-2]), 32'd0);
         check("t6_second", 32'(grant_q[grant_q.size()-1]), 32'd1);
      end
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/axil_req_arbiter.md
Name: axil_req_arbiter

Overview:
- Round-robin controller that shares one AXI4-Lite master port between NREQ local requesters, so that PL logic can read and write the 16-entry control register file alongside the PS path.
- Each requester issues single-word read/write commands on a valid/ready interface and gets a one-cycle response pulse.
- One transaction is in flight at a time.
- Sits between local engines and an AXI4-Lite slave (register file or interconnect slot).

Parameters:
- NREQ, 2, number of requesters (2..4).
- ADDR_WIDTH, 6, byte address width on the AXI side (16 x 32-bit registers).
- DATA_WIDTH, 32, data width; fixed at 32.

Ports:
- axi_aclk  in  1  single clock for all logic.
- axi_areset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  one-cycle grant/accept pulse, one-hot.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_WIDTH  packed byte addresses; bits [1:0] are ignored and driven 0.
- req_wdata  in  NREQ*32  packed write data.
- rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  32  read data, valid with rsp_valid; shared.
- rsp_err  out  1  resp[1] of BRESP/RRESP, valid with rsp_valid.
- busy  out  1  high whenever state != IDLE.
- M_AXI_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master signals, widths ADDR_WIDTH/3/1/1, 32/4/1/1, 2/1/1, ADDR_WIDTH/3/1/1, 32/2/1/1.

Behaviour:
- Reset (sync, axi_areset=1 at a clock edge):
  - state=IDLE; all valid/ready/rsp outputs 0; busy=0.
  - rsp_rdata=0, rsp_err=0.
  - RR pointer=0, so requester 0 has highest priority first.
  - Reset mid-transaction abandons it: no rsp_valid, and AXI valids drop on the next edge.
- Constant outputs: awprot=arprot=3'b000; wstrb=4'hF.
- States: IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
- IDLE:
  - If any req_valid, grant the first requester at or after the RR pointer (wrapping modulo NREQ).
  - Pulse req_ready[g]; latch write/addr/wdata into internal registers.
  - Next state WADDR or RADDR.
  - RR pointer becomes (g+1) mod NREQ.
  - Requesters hold their command stable while req_valid is high until ready.
- WADDR:
  - awvalid and wvalid both rise in the cycle after the grant.
  - Each drops independently on its own handshake (awready / wready).
  - When both are done, possibly in the same cycle, go to WRESP.
- WRESP: bready=1; on bvalid capture bresp, go to DONE.
- RADDR: arvalid=1 until arready, then go to RDATA.
- RDATA: rready=1; on rvalid capture rdata/rresp, go to DONE.
- DONE:
  - rsp_valid[g]=1 for exactly one cycle; rsp_rdata holds the captured value (0 for writes); rsp_err holds the captured resp[1].
  - Return to IDLE.
  - The earliest next grant is the cycle after DONE.
- Minimum latency with zero-wait slave responses:
  - Write: grant c0, AW/W c1, B c2, rsp_valid c3.
  - Read: grant c0, AR c1, R c2, rsp_valid c3.
- No timeout; a stalled slave holds the block in its wait state and busy stays 1.
- req_valid deasserted before grant: no transaction, no response.
- Single requester continuously valid: served every 4 cycles minimum.
- Requests arriving while busy wait; priority is re-evaluated only in IDLE.
- AXI valids never drop before their handshake; address/data stay stable while valid.

Test Plan:
- Reset, then req0 write addr 0x08 data 0x0000_0003 with a zero-wait slave -> req_ready[0] at c0; awvalid=wvalid=1 with awaddr=0x08, wdata=3, wstrb=F at c1; rsp_valid[0] at c3 with rsp_err=0.
- req1 read addr 0x00, slave returns 0xDEADBEEF after 3 wait cycles -> arvalid held until arready; rsp_valid[1] with rsp_rdata=0xDEADBEEF; busy low the cycle after.
- Both requesters valid continuously for 4 transactions from reset -> grant order 0,1,0,1; no rsp_valid to a non-owner.
- Slave asserts wready 2 cycles before awready -> wvalid drops after its handshake, awvalid held; bready only after both; a single rsp pulse.
- Slave returns BRESP=2'b10 -> rsp_err=1 with rsp_valid; next transaction has rsp_err=0.
- Assert axi_areset during WRESP -> next cycle bready=0, state IDLE, no rsp_valid; the next pending req0 is granted ahead of req1.
